// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Imported by the loader top and its byte packer.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INSTR      = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_INSTR = 4;
    localparam int          BCNT_W          = 2;

endpackage

// File: rtl/instruction_byte_packer.sv
// Packs UART bytes MSB-first into instruction words.
// Pulses word_valid on the edge that completes a word.
module instruction_byte_packer #(
    parameter int NB      = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_rx_done,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_word_valid,
    output logic [NB-1:0]      o_word
);
    import instruction_loader_pkg::*;

    logic [NB-1:0]     shift_q;
    logic [BCNT_W-1:0] cnt_q;
    logic              take;

    assign take         = i_enable & i_rx_done & ~i_clear;
    assign o_word       = {shift_q[NB-NB_BYTE-1:0], i_rx_data};
    assign o_word_valid = take &&
                          (cnt_q == BCNT_W'(BYTES_PER_INSTR - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (take) begin
            shift_q <= o_word;
            cnt_q   <= cnt_q + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads program words from the UART into instruction memory,
// detects HALT/overflow and gates pipeline stepping.
module instruction_loader #(
    parameter int          NB         = 32,
    parameter int          NB_BYTE    = 8,
    parameter int          TAM        = 256,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_rx_done,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_step_req,
    output logic               o_instruction_write,
    output logic [NB-1:0]      o_address_memory_ins,
    output logic [NB-1:0]      o_instruction,
    output logic               o_step,
    output logic               o_loading,
    output logic               o_load_done,
    output logic               o_error,
    output logic [NB-1:0]      o_count
);
    import instruction_loader_pkg::*;

    state_t        state;
    logic          word_valid;
    logic [NB-1:0] word;
    logic          capture;

    // Capture stays live in WRITE so a back-to-back byte is kept
    assign capture = (state == ST_RECV) || (state == ST_WRITE);

    instruction_byte_packer #(
        .NB      (NB),
        .NB_BYTE (NB_BYTE)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_start),
        .i_enable     (capture),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state                <= ST_IDLE;
            o_instruction_write  <= 1'b0;
            o_address_memory_ins <= '0;
            o_instruction        <= '0;
            o_count              <= '0;
        end else begin
            o_instruction_write <= 1'b0;
            if (i_start) begin
                state                <= ST_RECV;
                o_address_memory_ins <= '0;
                o_count              <= '0;
            end else begin
                case (state)
                    ST_RECV: begin
                        if (word_valid) begin
                            o_instruction       <= word;
                            o_instruction_write <= 1'b1;
                            state               <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        o_count <= o_count + NB'(1);
                        if (o_instruction == NB'(HALT_INSTR)) begin
                            state <= ST_DONE;
                        end else if (o_address_memory_ins == NB'(TAM - 1)) begin
                            state <= ST_ERROR;
                        end else begin
                            o_address_memory_ins <= o_address_memory_ins + NB'(1);
                            state                <= ST_RECV;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_loading   = (state == ST_RECV) || (state == ST_WRITE);
    assign o_load_done = (state == ST_DONE);
    assign o_error     = (state == ST_ERROR);
    assign o_step      = (state == ST_DONE) & i_step_req;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader with a small memory depth
// so the overflow path is reachable.
module tb_instruction_loader;

    localparam int          TAM  = 4;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_step_req;
    logic        o_instruction_write;
    logic [31:0] o_address_memory_ins;
    logic [31:0] o_instruction;
    logic        o_step;
    logic        o_loading;
    logic        o_load_done;
    logic        o_error;
    logic [31:0] o_count;

    instruction_loader #(
        .NB         (32),
        .NB_BYTE    (8),
        .TAM        (TAM),
        .HALT_INSTR (HALT)
    ) dut (
        .i_clk                (i_clk),
        .i_reset              (i_reset),
        .i_start              (i_start),
        .i_rx_done            (i_rx_done),
        .i_rx_data            (i_rx_data),
        .i_step_req           (i_step_req),
        .o_instruction_write  (o_instruction_write),
        .o_address_memory_ins (o_address_memory_ins),
        .o_instruction        (o_instruction),
        .o_step               (o_step),
        .o_loading            (o_loading),
        .o_load_done          (o_load_done),
        .o_error              (o_error),
        .o_count              (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected write
    always @(negedge i_clk) begin
        if (i_reset && o_instruction_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         o_address_memory_ins, o_instruction);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", o_address_memory_ins, mon_e[63:32]);
                chk("wr_data", o_instruction, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        chk("step_while_loading", {31'b0, o_step}, 32'd0);
        repeat ($urandom_range(gap_max)) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap_max);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_write"}, {31'b0, o_instruction_write}, 32'd0);
        chk({tag, "_addr"}, o_address_memory_ins, 32'd0);
        chk({tag, "_instr"}, o_instruction, 32'd0);
        chk({tag, "_step"}, {31'b0, o_step}, 32'd0);
        chk({tag, "_loading"}, {31'b0, o_loading}, 32'd0);
        chk({tag, "_done"}, {31'b0, o_load_done}, 32'd0);
        chk({tag, "_error"}, {31'b0, o_error}, 32'd0);
        chk({tag, "_count"}, o_count, 32'd0);
    endtask

    // Reference: words land at 0,1,2.. until HALT or memory is full
    task automatic run_prog(input logic [31:0] words[$], input int gap_max);
        int n;
        bit halted;
        n = 0;
        halted = 1'b0;
        i_step_req = 1'b1;
        pulse_start();
        chk("start_loading", {31'b0, o_loading}, 32'd1);
        chk("start_error", {31'b0, o_error}, 32'd0);
        chk("start_count", o_count, 32'd0);
        foreach (words[i]) begin
            exp_q.push_back({32'(i), words[i]});
            n++;
            if (words[i] == HALT) begin
                halted = 1'b1;
                break;
            end
            if (i == TAM - 1) break;
        end
        foreach (words[i]) send_word(words[i], gap_max);
        repeat (2) tick();
        chk("end_done", {31'b0, o_load_done}, {31'b0, halted});
        chk("end_error", {31'b0, o_error}, {31'b0, !halted});
        chk("end_count", o_count, 32'(n));
        chk("end_loading", {31'b0, o_loading}, 32'd0);
        chk("end_step_req1", {31'b0, o_step}, {31'b0, halted});
        i_step_req = 1'b0;
        #1;
        chk("end_step_req0", {31'b0, o_step}, 32'd0);
        i_step_req = 1'b1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] v;
        do v = $urandom; while (v == HALT);
        return v;
    endfunction

    initial begin
        logic [31:0] prog[$];
        int n;
        bit halt_end;

        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_rx_done  = 1'b0;
        i_rx_data  = 8'h00;
        i_step_req = 1'b1;
        #2;
        chk_reset_outputs("reset");
        tick();
        tick();
        i_reset = 1'b1;

        // Bytes in IDLE are ignored
        send_byte(8'h5A, 0);
        chk("idle_loading", {31'b0, o_loading}, 32'd0);

        prog = '{32'h2001_0005, 32'h0000_0000, HALT};
        run_prog(prog, 2);

        prog = '{rnd_word(), rnd_word(), rnd_word(), rnd_word()};
        run_prog(prog, 1);

        // Partial word dropped on restart
        pulse_start();
        send_byte(8'hAB, 1);
        send_byte(8'hCD, 1);
        prog = '{32'h0000_0007, HALT};
        run_prog(prog, 1);

        // Zero gap puts the next word's first byte in the WRITE cycle
        prog = '{32'h1234_5678, 32'h9ABC_DEF0, HALT};
        run_prog(prog, 0);

        // Reset mid-load after six bytes
        pulse_start();
        exp_q.push_back({32'd0, 32'h1122_3344});
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        i_reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        i_reset = 1'b1;
        prog = '{32'h0000_000A, HALT};
        run_prog(prog, 1);

        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(TAM, 1);
            halt_end = (n < TAM) ? 1'b1 : 1'($urandom_range(1));
            prog = {};
            for (int i = 0; i < n - 1; i++) prog.push_back(rnd_word());
            prog.push_back(halt_end ? HALT : rnd_word());
            run_prog(prog, 2);
        end

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Sequences the instruction memory's load phase before execution. It receives program bytes from the debug unit's UART receiver and packs each group of four into a 32-bit instruction. Each instruction is written to consecutive word addresses of instruction_memory through its write port. It detects the HALT word, flags overflow, and gates pipeline stepping so the fetch stage only reads memory after a complete load.

Parameters:
NB, 32, instruction and address width
NB_BYTE, 8, UART byte width
TAM, 256, instruction memory depth in words
HALT_INSTR, 32'hFFFF_FFFF, end-of-program marker

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous reset, active-low
i_start  in  1  one-cycle pulse that begins (or restarts) a load
i_rx_done  in  1  one-cycle pulse, i_rx_data valid
i_rx_data  in  NB_BYTE  received byte
i_step_req  in  1  step request from the debug unit
o_instruction_write  out  1  write strobe to instruction_memory (i_instruction_write)
o_address_memory_ins  out  NB  word write address
o_instruction  out  NB  instruction word to write
o_step  out  1  step enable to fetch (i_step)
o_loading  out  1  high in RECV and WRITE
o_load_done  out  1  high in DONE
o_error  out  1  high in ERROR
o_count  out  NB  instructions written in the current load, HALT included

Behaviour:
- Reset (i_reset==0, asynchronous): state IDLE. All outputs 0. Byte buffer, byte counter, address and count all 0.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- i_start has priority in every state. Next state is RECV, with byte count, address and o_count cleared and o_error cleared. A coincident i_rx_done byte is discarded.
- IDLE: waits for i_start. Bytes are ignored.
- RECV:
  - On each i_rx_done, shift into the buffer as buf <= {buf[23:0], rx}. First byte is the MSB.
  - When the 4th byte arrives, load o_instruction with the completed word in the same edge. Byte count returns to 0 and the next state is WRITE.
- WRITE, exactly one cycle:
  - o_instruction_write=1, registered.
  - o_address_memory_ins and o_instruction are already stable from the previous edge. This setup is required because the memory captures on the strobe's rising edge.
- Leaving WRITE:
  - o_count increments.
  - If o_instruction==HALT_INSTR, go to DONE. The address is held.
  - Else if o_address_memory_ins==TAM-1, go to ERROR (memory full without HALT).
  - Else increment the address and return to RECV.
- Byte capture stays active during WRITE, so a byte arriving in WRITE is not lost.
- o_address_memory_ins and o_instruction hold their last values outside writes.
- DONE:
  - o_load_done=1.
  - o_step = i_step_req, combinational. o_step is 0 in every other state, so the pipeline never fetches a partially loaded program.
  - Further bytes are ignored.
- ERROR: o_error=1, sticky until i_start or reset. Bytes are ignored and o_step=0.
- Partial word on restart: a 1–3 byte partial word is dropped.
- Latency: WRITE follows the 4th byte by one cycle, so there is one strobe per instruction.
- Reset mid-load: returns immediately to IDLE with o_instruction_write low. Memory contents already written are untouched.

Decomposition:
- Shared package instruction_loader_pkg holds:
  - state encodings (3-bit localparams)
  - HALT_INSTR
  - BYTES_PER_INSTR=4 and the 2-bit byte-counter width
- One sub-module is natural: instruction_byte_packer. It holds the shift buffer and byte counter and produces a word_valid pulse plus the 32-bit word. The FSM, address counter and step gating stay in the top.

Test Plan:
- Load path: reset, i_start, send bytes 20 01 00 05, 00 00 00 00, FF FF FF FF.
  - Required: three strobes at addresses 0, 1, 2 with data 32'h2001_0005, 0, 32'hFFFF_FFFF.
  - Then o_load_done=1, o_count=3.
- Step gating: assert i_step_req during the load, then after DONE.
  - Required: o_step=0 throughout the load; o_step follows i_step_req in DONE.
- Overflow: TAM=4, send 4 non-HALT words.
  - Required: strobes at addresses 0–3, then o_error=1, o_step=0.
  - Then i_start clears o_error.
- Restart: send 2 bytes, pulse i_start, send 00 00 00 07, FF FF FF FF.
  - Required: first write is 32'h0000_0007 at address 0.
- Byte during WRITE: deliver the 5th byte in the WRITE cycle.
  - Required: the next word is assembled correctly.
- Reset mid-load: deassert i_reset after 6 bytes.
  - Required: immediate IDLE with all outputs 0. A new load starts at address 0.
